// File: rtl/booth_r4_defs.sv
// rtl/booth_r4_defs.sv - shared encodings and helpers for the radix-4 Booth multiplier
package booth_r4_defs;

  typedef enum logic [2:0] {
    ZERO     = 3'd0,
    PLUS_M   = 3'd1,
    PLUS_2M  = 3'd2,
    MINUS_M  = 3'd3,
    MINUS_2M = 3'd4
  } booth_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  // Radix-4 recoding consumes two multiplier bits per step, so N must be even.
  function automatic bit n_is_valid(input int n);
    return (n >= 4) && ((n % 2) == 0);
  endfunction

  function automatic booth_op_e booth_decode(input logic [2:0] w);
    booth_op_e op;
    case (w)
      3'b001, 3'b010: op = PLUS_M;
      3'b011:         op = PLUS_2M;
      3'b100:         op = MINUS_2M;
      3'b101, 3'b110: op = MINUS_M;
      default:        op = ZERO;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/booth_r4_encoder.sv
// rtl/booth_r4_encoder.sv - radix-4 Booth window to neg/two/zero select lines
module booth_r4_encoder
  import booth_r4_defs::*;
(
  input  logic [2:0] window,
  output logic       neg,
  output logic       two,
  output logic       zero
);

  booth_op_e op;

  assign op   = booth_decode(window);
  assign neg  = (op == MINUS_M) || (op == MINUS_2M);
  assign two  = (op == PLUS_2M) || (op == MINUS_2M);
  assign zero = (op == ZERO);

endmodule

// File: rtl/booth_r4_seq_mul.sv
// rtl/booth_r4_seq_mul.sv - sequential signed radix-4 Booth multiplier, one step per clock
module booth_r4_seq_mul
  import booth_r4_defs::*;
#(
  parameter int N = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [N-1:0]     a,
  input  logic [N-1:0]     b,
  output logic             busy,
  output logic             done,
  output logic [2*N-1:0]   product
);

  localparam int W     = N + 2;
  localparam int STEPS = N / 2;
  localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(STEPS - 1);

  if (!n_is_valid(N)) begin : g_bad_n
    $error("booth_r4_seq_mul: N must be even and at least 4");
  end

  state_e               state_q, state_d;
  logic [W-1:0]         m_q, m_d;
  logic [W-1:0]         p_q, p_d;
  logic [N:0]           q_q, q_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2*N-1:0]       product_q, product_d;

  logic                 neg, two, zero;
  logic [W-1:0]         sel_mag, sel, addend, s;
  logic [W-1:0]         p_shift;
  logic [N:0]           q_shift;

  booth_r4_encoder u_enc (
    .window (q_q[2:0]),
    .neg    (neg),
    .two    (two),
    .zero   (zero)
  );

  // M is already sign-extended by two bits, so 2M is a plain left shift.
  always_comb begin
    sel_mag = two ? {m_q[W-2:0], 1'b0} : m_q;
    sel     = zero ? '0 : sel_mag;
    addend  = neg ? ~sel : sel;
    s       = p_q + addend + {{(W-1){1'b0}}, neg};
    p_shift = {{2{s[W-1]}}, s[W-1:2]};
    q_shift = {s[1:0], q_q[N:2]};
  end

  always_comb begin
    state_d   = state_q;
    m_d       = m_q;
    p_d       = p_q;
    q_d       = q_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          m_d     = {{2{a[N-1]}}, a};
          q_d     = {b, 1'b0};
          p_d     = '0;
          cnt_d   = '0;
          state_d = CALC;
        end else begin
          state_d = IDLE;
        end
      end
      CALC: begin
        p_d   = p_shift;
        q_d   = q_shift;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_CNT) begin
          product_d = {p_shift[N-1:0], q_shift[N:1]};
          state_d   = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      m_q       <= '0;
      p_q       <= '0;
      q_q       <= '0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      m_q       <= m_d;
      p_q       <= p_d;
      q_q       <= q_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

  assign busy    = (state_q == CALC);
  assign done    = (state_q == DONE);
  assign product = product_q;

endmodule
